main_control_fsm: RTL and testbench

Multi-cycle main control unit for the CPU datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states from the 6-bit opcode. It drives all datapath enables and muxes, and produces the 3-bit `aluop` consumed by the ALU control decoder. Memory states stall on a `memready` handshake.

---
 rtl/main_control_fsm.sv | 160 ++++++++++++++++
 tb/tb_main_control_fsm.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback
// from the opcode and drives every datapath enable, mux select and aluop.
module main_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       memready,
    output logic       pcen,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       irwrite,
    output logic       alusrca,
    output logic       regwrite,
    output logic       regdst,
    output logic [1:0] pcsource,
    output logic [1:0] alusrcb,
    output logic [2:0] aluop,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12,
        S_ILLEGAL = 4'd13
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = S_IDLE;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        irwrite     = 1'b0;
        alusrca     = 1'b0;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        pcsource    = 2'b00;
        alusrcb     = 2'b00;
        aluop       = 3'b000;
        illegal     = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = memready;
                pcwrite = memready;
                w_next  = memready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYP:      w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                // Opcode is re-sampled here; anything but lw/sw is flagged.
                if (opcode == OP_LW)      w_next = S_MEMRD;
                else if (opcode == OP_SW) w_next = S_MEMWR;
                else                      w_next = S_ILLEGAL;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                w_next  = memready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                w_next   = memready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = 3'b100;
                w_next  = S_RWB;
            end
            S_RWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 3'b001;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
                w_next      = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
                w_next   = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                w_next  = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign pcen  = pcwrite | (pcwritecond & zero);
    assign state = r_state;

endmodule

// File: tb/tb_main_control_fsm.sv
// Table-driven bench for main_control_fsm: per-cycle input/expected-state vectors
// checked through a scoreboard against per-state output words.
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
    logic       memready = 1'b1;
    logic       pcen, pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
    logic       irwrite, alusrca, regwrite, regdst, illegal;
    logic [1:0] pcsource, alusrcb;
    logic [2:0] aluop;
    logic [3:0] state;

    main_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .memready(memready),
        .pcen(pcen), .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg), .irwrite(irwrite),
        .alusrca(alusrca), .regwrite(regwrite), .regdst(regdst), .pcsource(pcsource),
        .alusrcb(alusrcb), .aluop(aluop), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

    typedef struct packed {
        logic       rst_n;
        logic [5:0] op;
        logic       z;
        logic       mr;
        logic [3:0] st;
    } vec_t;

    typedef struct {
        logic [22:0] w;
        string       tag;
    } exp_t;

    // Word layout: pcwrite,pcwritecond,iord,memread,memwrite,memtoreg,irwrite,
    // alusrca,regwrite,regdst,pcsource[2],alusrcb[2],aluop[3],illegal
    logic [17:0] out_word [16];
    vec_t        vecs[$];
    exp_t        sb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    function automatic logic [22:0] expect_out(logic [3:0] st, logic z, logic mr);
        logic [17:0] w;
        w = out_word[st];
        if (st == 4'd1 && !mr) begin
            w[17] = 1'b0;
            w[11] = 1'b0;
        end
        return {w[17] | (w[16] & z), w, st};
    endfunction

    task automatic compare_now(input logic [3:0] st, input string tag);
        exp_t        e;
        logic [22:0] got;
        e.w = expect_out(st, zero, memready);
        e.tag = tag;
        sb.push_back(e);
        #1;
        got = {pcen, pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
               alusrca, regwrite, regdst, pcsource, alusrcb, aluop, illegal, state};
        e = sb.pop_front();
        n_tests++;
        if (got !== e.w) begin
            n_fail++;
            $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                     e.tag, got[3:0], got[22:4], e.w[3:0], e.w[22:4]);
        end
    endtask

    task automatic drive_and_check(input vec_t v, input string tag);
        rst_n    = v.rst_n;
        opcode   = v.op;
        zero     = v.z;
        memready = v.mr;
        compare_now(v.st, tag);
    endtask

    task automatic add(input logic [5:0] op, input logic z, input logic mr, input logic [3:0] st);
        vecs.push_back('{1'b1, op, z, mr, st});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        out_word[0]  = 18'b0000000000_00_00_000_0;
        out_word[1]  = 18'b1001001000_00_01_000_0;
        out_word[2]  = 18'b0000000000_00_11_000_0;
        out_word[3]  = 18'b0000000100_00_10_000_0;
        out_word[4]  = 18'b0011000000_00_00_000_0;
        out_word[5]  = 18'b0000010010_00_00_000_0;
        out_word[6]  = 18'b0010100000_00_00_000_0;
        out_word[7]  = 18'b0000000100_00_00_100_0;
        out_word[8]  = 18'b0000000011_00_00_000_0;
        out_word[9]  = 18'b0100000100_01_00_001_0;
        out_word[10] = 18'b0000000100_00_10_000_0;
        out_word[11] = 18'b0000000010_00_00_000_0;
        out_word[12] = 18'b1000000000_10_00_000_0;
        out_word[13] = 18'b0000000000_00_00_000_1;
        out_word[14] = '0;
        out_word[15] = '0;

        // First record releases reset; the FSM must still show IDLE that cycle.
        add(RT, 1'b0, 1'b1, 4'd0);
        add(LW, 1'b0, 1'b0, 4'd1); add(LW, 1'b0, 1'b0, 4'd1); add(LW, 1'b0, 1'b1, 4'd1);
        add(LW, 1'b0, 1'b1, 4'd2); add(LW, 1'b0, 1'b1, 4'd3); add(LW, 1'b0, 1'b0, 4'd4);
        add(LW, 1'b0, 1'b1, 4'd4); add(LW, 1'b0, 1'b1, 4'd5);
        add(RT, 1'b0, 1'b1, 4'd1); add(RT, 1'b0, 1'b1, 4'd2); add(RT, 1'b0, 1'b1, 4'd7);
        add(RT, 1'b0, 1'b1, 4'd8);
        add(BEQ, 1'b1, 1'b1, 4'd1); add(BEQ, 1'b1, 1'b1, 4'd2); add(BEQ, 1'b1, 1'b1, 4'd9);
        add(BEQ, 1'b0, 1'b1, 4'd1); add(BEQ, 1'b0, 1'b1, 4'd2); add(BEQ, 1'b0, 1'b1, 4'd9);
        add(ADDI, 1'b0, 1'b1, 4'd1); add(ADDI, 1'b1, 1'b1, 4'd2); add(ADDI, 1'b1, 1'b1, 4'd10);
        add(ADDI, 1'b1, 1'b1, 4'd11);
        add(JMP, 1'b0, 1'b1, 4'd1); add(JMP, 1'b0, 1'b1, 4'd2); add(JMP, 1'b1, 1'b1, 4'd12);
        add(BAD, 1'b0, 1'b1, 4'd1); add(BAD, 1'b0, 1'b1, 4'd2); add(BAD, 1'b1, 1'b1, 4'd13);

        for (int unsigned c = 0; c < 3; c++) begin
            @(negedge clk);
            drive_and_check('{1'b0, RT, 1'b0, 1'b1, 4'd0}, "reset_hold");
        end

        for (int unsigned i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive_and_check(vecs[i], $sformatf("vec%0d", i));
        end

        // sw stalled in MEMWR, then reset mid-cycle aborts it.
        @(negedge clk); drive_and_check('{1'b1, SW, 1'b0, 1'b1, 4'd1}, "sw_fetch");
        @(negedge clk); drive_and_check('{1'b1, SW, 1'b0, 1'b1, 4'd2}, "sw_decode");
        @(negedge clk); drive_and_check('{1'b1, SW, 1'b0, 1'b1, 4'd3}, "sw_memadr");
        @(negedge clk); drive_and_check('{1'b1, SW, 1'b0, 1'b0, 4'd6}, "sw_stall1");
        @(negedge clk); drive_and_check('{1'b1, SW, 1'b0, 1'b0, 4'd6}, "sw_stall2");
        #2 rst_n = 1'b0;
        compare_now(4'd0, "async_reset");
        @(negedge clk); drive_and_check('{1'b0, SW, 1'b0, 1'b0, 4'd0}, "reset_low");
        @(negedge clk); drive_and_check('{1'b1, SW, 1'b0, 1'b0, 4'd0}, "reset_release");
        @(negedge clk); drive_and_check('{1'b1, SW, 1'b0, 1'b0, 4'd1}, "fetch_resume");
        @(negedge clk); drive_and_check('{1'b1, SW, 1'b1, 1'b1, 4'd1}, "fetch_ready");
        @(negedge clk); drive_and_check('{1'b1, SW, 1'b0, 1'b1, 4'd2}, "decode_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
